// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the barrel-threaded core's execution trace buffer.
package riscv_pkg;

    localparam int TRACE_TID_W  = 4;
    localparam int TRACE_ADDR_W = 14;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_SEQ_W  = 16;

    typedef enum logic {
        TRACE_REG = 1'b0,
        TRACE_MEM = 1'b1
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e             kind;
        logic [TRACE_TID_W-1:0]  tid;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
        logic [3:0]              be;
        logic [TRACE_SEQ_W-1:0]  seq;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } trace_state_e;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// trace_fifo_2w1r: register-array FIFO taking up to two writes and one read per cycle, first-word fall-through.
module trace_fifo_2w1r #(
    parameter int  DEPTH   = 32,
    parameter type entry_t = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en0,
    input  entry_t                 wr_data0,
    input  logic                   wr_en1,
    input  entry_t                 wr_data1,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output entry_t                 rd_data,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr1;
    logic          pop;

    assign wr_ptr1  = wr_ptr + (AW+1)'(1);
    assign level    = wr_ptr - rd_ptr;
    assign rd_valid = level != '0;
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign pop      = rd_en && rd_valid;

    // The writer guarantees space, so no full check here; wr_en1 is only ever set together with wr_en0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(wr_en0) + (AW+1)'(wr_en1);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en0) mem[wr_ptr[AW-1:0]] <= wr_data0;
        if (wr_en1) mem[wr_ptr1[AW-1:0]] <= wr_data1;
    end

endmodule

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: snoops register writeback and store ports, stamps qualifying events and streams them out.
module exec_trace_buffer
    import riscv_pkg::*;
#(
    parameter int NUM_THREADS = 16,
    parameter int TID_WIDTH   = 4,
    parameter int DEPTH       = 32,
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 32,
    parameter int SEQ_WIDTH   = 16,
    parameter bit FILTER_X0   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     regfile_wr_en,
    input  logic [4:0]               regfile_wr_addr,
    input  logic [DATA_WIDTH-1:0]    regfile_wr_data,
    input  logic [TID_WIDTH-1:0]     thread_index_wb,
    input  logic [3:0]               dmem_write_enable,
    input  logic [ADDR_WIDTH-1:0]    dmem_addr,
    input  logic [DATA_WIDTH-1:0]    dmem_write_data,
    input  logic [TID_WIDTH-1:0]     thread_index_wrmem,
    input  logic                     cfg_enable,
    input  logic                     cfg_stop_on_full,
    input  logic [NUM_THREADS-1:0]   cfg_thread_mask,
    output logic                     o_trace_valid,
    input  logic                     i_trace_ready,
    output logic                     o_trace_kind,
    output logic [TID_WIDTH-1:0]     o_trace_tid,
    output logic [ADDR_WIDTH-1:0]    o_trace_addr,
    output logic [DATA_WIDTH-1:0]    o_trace_data,
    output logic [3:0]               o_trace_be,
    output logic [SEQ_WIDTH-1:0]     o_trace_seq,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [15:0]              o_overflow_count,
    output logic                     o_frozen
);
    localparam int LW = $clog2(DEPTH) + 1;

    trace_state_e       state;
    logic [SEQ_WIDTH-1:0] seq;
    logic [LW-1:0]      free;
    logic               reg_ev, mem_ev, head_valid;
    logic [1:0]         n_ev, n_acc, n_drop;
    logic [16:0]        ovf_sum;
    trace_entry_t       reg_entry, mem_entry, head;

    assign reg_ev = state == CAPTURE && regfile_wr_en && cfg_thread_mask[thread_index_wb]
                    && !(FILTER_X0 && regfile_wr_addr == 5'd0);
    assign mem_ev = state == CAPTURE && |dmem_write_enable && cfg_thread_mask[thread_index_wrmem];
    assign n_ev   = {1'b0, reg_ev} + {1'b0, mem_ev};

    // Space is judged on the registered level only; a same-cycle pop does not free a slot.
    assign free   = LW'(DEPTH) - o_level;
    assign n_acc  = free == '0 ? 2'd0 : (free == LW'(1) && n_ev == 2'd2) ? 2'd1 : n_ev;
    assign n_drop = n_ev - n_acc;
    assign ovf_sum = {1'b0, o_overflow_count} + 17'(n_drop);

    assign reg_entry = '{kind: TRACE_REG, tid: thread_index_wb, addr: ADDR_WIDTH'(regfile_wr_addr),
                         data: regfile_wr_data, be: 4'hF, seq: seq};
    assign mem_entry = '{kind: TRACE_MEM, tid: thread_index_wrmem, addr: dmem_addr,
                         data: dmem_write_data, be: dmem_write_enable, seq: seq + SEQ_WIDTH'(reg_ev)};

    trace_fifo_2w1r #(.DEPTH(DEPTH), .entry_t(trace_entry_t)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en0   (n_acc != 2'd0),
        .wr_data0 (reg_ev ? reg_entry : mem_entry),
        .wr_en1   (n_acc == 2'd2),
        .wr_data1 (mem_entry),
        .rd_en    (i_trace_ready),
        .rd_valid (head_valid),
        .rd_data  (head),
        .level    (o_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            seq              <= '0;
            o_overflow_count <= '0;
        end else begin
            seq              <= seq + SEQ_WIDTH'(n_ev);
            o_overflow_count <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
            state            <= state == IDLE ? (cfg_enable ? CAPTURE : IDLE) :
                                !cfg_enable ? IDLE :
                                (state == CAPTURE && cfg_stop_on_full && n_drop != 2'd0) ? FROZEN : state;
        end
    end

    // Storage is not reset, so the head is masked to keep idle outputs at zero.
    assign o_trace_valid = head_valid;
    assign o_trace_kind  = head_valid & head.kind;
    assign o_trace_tid   = head_valid ? head.tid  : '0;
    assign o_trace_addr  = head_valid ? head.addr : '0;
    assign o_trace_data  = head_valid ? head.data : '0;
    assign o_trace_be    = head_valid ? head.be   : '0;
    assign o_trace_seq   = head_valid ? head.seq  : '0;
    assign o_frozen      = state == FROZEN;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb_exec_trace_buffer: directed and randomized checks of exec_trace_buffer against a queue-based model.
module tb_exec_trace_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        regfile_wr_en;
    logic [4:0]  regfile_wr_addr;
    logic [31:0] regfile_wr_data;
    logic [3:0]  thread_index_wb;
    logic [3:0]  dmem_write_enable;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_write_data;
    logic [3:0]  thread_index_wrmem;
    logic        cfg_enable, cfg_stop_on_full;
    logic [15:0] cfg_thread_mask;
    logic        o_trace_valid, i_trace_ready, o_trace_kind;
    logic [3:0]  o_trace_tid;
    logic [13:0] o_trace_addr;
    logic [31:0] o_trace_data;
    logic [3:0]  o_trace_be;
    logic [15:0] o_trace_seq;
    logic [2:0]  o_level;
    logic [15:0] o_overflow_count;
    logic        o_frozen;

    always #5 clk = ~clk;

    exec_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .regfile_wr_en(regfile_wr_en), .regfile_wr_addr(regfile_wr_addr),
        .regfile_wr_data(regfile_wr_data), .thread_index_wb(thread_index_wb),
        .dmem_write_enable(dmem_write_enable), .dmem_addr(dmem_addr),
        .dmem_write_data(dmem_write_data), .thread_index_wrmem(thread_index_wrmem),
        .cfg_enable(cfg_enable), .cfg_stop_on_full(cfg_stop_on_full),
        .cfg_thread_mask(cfg_thread_mask),
        .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_kind(o_trace_kind), .o_trace_tid(o_trace_tid),
        .o_trace_addr(o_trace_addr), .o_trace_data(o_trace_data),
        .o_trace_be(o_trace_be), .o_trace_seq(o_trace_seq),
        .o_level(o_level), .o_overflow_count(o_overflow_count), .o_frozen(o_frozen)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: captured entries in order, next stamp, drop count, and mode 0 idle / 1 capturing / 2 frozen.
    logic [70:0] q[$];
    logic [15:0] mseq;
    logic [15:0] movf;
    int          mode;

    function automatic logic [70:0] head_word();
        return {o_trace_kind, o_trace_tid, o_trace_addr, o_trace_data, o_trace_be, o_trace_seq};
    endfunction

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 71'(o_trace_valid), 71'(q.size() > 0));
        chk("level", 71'(o_level), 71'(q.size()));
        chk("overflow", 71'(o_overflow_count), 71'(movf));
        chk("frozen", 71'(o_frozen), 71'(mode == 2));
        if (q.size() > 0) chk("head", head_word(), q[0]);
    endtask

    task automatic model_edge();
        logic [70:0] ev[$];
        logic [70:0] e;
        int free, drops;
        drops = 0;
        if (mode == 1) begin
            if (regfile_wr_en && cfg_thread_mask[thread_index_wb] && regfile_wr_addr != 5'd0)
                ev.push_back({1'b0, thread_index_wb, 14'(regfile_wr_addr), regfile_wr_data, 4'hF, 16'h0});
            if (dmem_write_enable != 4'h0 && cfg_thread_mask[thread_index_wrmem])
                ev.push_back({1'b1, thread_index_wrmem, dmem_addr, dmem_write_data, dmem_write_enable, 16'h0});
        end
        free = DEPTH - q.size();
        if (i_trace_ready && q.size() > 0) void'(q.pop_front());
        foreach (ev[i]) begin
            e = ev[i];
            e[15:0] = mseq;
            mseq = mseq + 16'd1;
            if (free > 0) begin
                q.push_back(e);
                free--;
            end else drops++;
        end
        movf = (int'(movf) + drops > 65535) ? 16'hFFFF : movf + 16'(drops);
        if (mode == 0) mode = cfg_enable ? 1 : 0;
        else if (!cfg_enable) mode = 0;
        else if (mode == 1 && cfg_stop_on_full && drops > 0) mode = 2;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clr();
        regfile_wr_en = 1'b0;
        dmem_write_enable = 4'h0;
    endtask

    task automatic reg_wr(input logic [3:0] tid, input logic [4:0] a, input logic [31:0] d);
        regfile_wr_en = 1'b1; thread_index_wb = tid; regfile_wr_addr = a; regfile_wr_data = d;
    endtask

    task automatic mem_wr(input logic [3:0] tid, input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
        dmem_write_enable = be; thread_index_wrmem = tid; dmem_addr = a; dmem_write_data = d;
    endtask

    initial begin
        reset = 1'b0;
        regfile_wr_en = 0; regfile_wr_addr = 0; regfile_wr_data = 0; thread_index_wb = 0;
        dmem_write_enable = 0; dmem_addr = 0; dmem_write_data = 0; thread_index_wrmem = 0;
        cfg_enable = 0; cfg_stop_on_full = 0; cfg_thread_mask = 0; i_trace_ready = 0;
        mseq = 0; movf = 0; mode = 0;
        #12;
        check_all();
        chk("reset_data", 71'(o_trace_data), 71'(0));
        reset = 1'b1;
        cfg_enable = 1'b1; cfg_thread_mask = 16'hFFFF;
        step();

        // Single register write.
        reg_wr(4'd3, 5'd5, 32'h1234);
        step();
        clr();
        chk("t1_head", head_word(), {1'b0, 4'd3, 14'd5, 32'h1234, 4'hF, 16'd0});
        i_trace_ready = 1'b1; step(); i_trace_ready = 1'b0;

        // Simultaneous register write and store.
        reg_wr(4'd2, 5'd1, 32'hAAAA);
        mem_wr(4'd7, 14'h10, 4'h3, 32'hBEEF);
        step();
        clr();
        chk("t2_level", 71'(o_level), 71'(2));
        chk("t2_reg", head_word(), {1'b0, 4'd2, 14'd1, 32'hAAAA, 4'hF, 16'd1});
        i_trace_ready = 1'b1; step();
        chk("t2_mem", head_word(), {1'b1, 4'd7, 14'h10, 32'hBEEF, 4'h3, 16'd2});
        step(); i_trace_ready = 1'b0;

        // Thread mask and x0 filtering.
        cfg_thread_mask = 16'h0001;
        reg_wr(4'd0, 5'd4, 32'h44); mem_wr(4'd1, 14'h20, 4'hF, 32'h55); step(); clr();
        reg_wr(4'd1, 5'd6, 32'h66); step(); clr();
        reg_wr(4'd0, 5'd0, 32'h77); step(); clr();
        chk("t3_level", 71'(o_level), 71'(1));
        chk("t3_seq", 71'(o_trace_seq), 71'(3));
        i_trace_ready = 1'b1; step(); i_trace_ready = 1'b0;

        // Fill past capacity, drop-and-count mode.
        cfg_thread_mask = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin reg_wr(4'd1, 5'(i + 1), 32'(i)); step(); end
        clr();
        chk("t4_level", 71'(o_level), 71'(4));
        chk("t4_ovf", 71'(o_overflow_count), 71'(2));
        chk("t4_seq", 71'(o_trace_seq), 71'(4));
        i_trace_ready = 1'b1; for (int i = 0; i < 4; i++) step(); i_trace_ready = 1'b0;

        // Fill past capacity, stop-on-full mode, then re-arm.
        cfg_stop_on_full = 1'b1;
        for (int i = 0; i < 6; i++) begin reg_wr(4'd9, 5'(i + 1), 32'(100 + i)); step(); end
        clr();
        chk("t5_frozen", 71'(o_frozen), 71'(1));
        chk("t5_ovf", 71'(o_overflow_count), 71'(3));
        i_trace_ready = 1'b1; for (int i = 0; i < 4; i++) step(); i_trace_ready = 1'b0;
        cfg_enable = 1'b0; step();
        cfg_enable = 1'b1; step();
        cfg_stop_on_full = 1'b0;
        reg_wr(4'd4, 5'd8, 32'h88); step(); clr();
        chk("t5_resume_seq", 71'(o_trace_seq), 71'(15));
        i_trace_ready = 1'b1; step(); i_trace_ready = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cfg_enable       = $urandom_range(0, 19) != 0;
            cfg_stop_on_full = $urandom_range(0, 7) == 0;
            cfg_thread_mask  = 16'($urandom | $urandom);
            i_trace_ready    = $urandom_range(0, 1) == 1;
            regfile_wr_en    = $urandom_range(0, 1) == 1;
            regfile_wr_addr  = 5'($urandom);
            regfile_wr_data  = $urandom;
            thread_index_wb  = 4'($urandom);
            dmem_write_enable = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
            dmem_addr        = 14'($urandom);
            dmem_write_data  = $urandom;
            thread_index_wrmem = 4'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a drain.
        clr();
        cfg_enable = 1'b0; cfg_stop_on_full = 1'b0; cfg_thread_mask = 16'hFFFF;
        i_trace_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        cfg_enable = 1'b1; i_trace_ready = 1'b0; step();
        for (int i = 0; i < 3; i++) begin reg_wr(4'd5, 5'(i + 10), 32'(i)); step(); end
        clr();
        chk("t6_level", 71'(o_level), 71'(3));
        i_trace_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        q.delete(); mseq = 0; movf = 0; mode = 0;
        chk("t6_valid", 71'(o_trace_valid), 71'(0));
        chk("t6_level0", 71'(o_level), 71'(0));
        chk("t6_ovf0", 71'(o_overflow_count), 71'(0));
        check_all();
        #20;
        reset = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_trace_buffer.md
Name: exec_trace_buffer

Overview:
- Synthesizable on-chip trace capture for the barrel-threaded RISC-V core.
- Snoops the core's debug ports (register-file writeback and data-memory write) and stamps each qualifying event with thread ID and sequence number.
- Buffers events in a dual-write FIFO and drains them over a valid/ready stream to MMIO, UART or the bench.
- Generalises simulation-only register/memory dumping to N threads, with per-thread filtering, overflow accounting and stop-on-full mode.

Parameters:
- NUM_THREADS, 16, number of hardware threads; one mask bit per thread.
- TID_WIDTH, 4, thread index width; must equal $clog2(NUM_THREADS).
- DEPTH, 32, FIFO entries; power of two, at least 4.
- ADDR_WIDTH, 14, dmem address width; register address is zero-extended to this.
- DATA_WIDTH, 32, write-data width.
- SEQ_WIDTH, 16, sequence-stamp width; wraps.
- FILTER_X0, 1, when 1, register writes to x0 are not events.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- regfile_wr_en  in  1  register writeback strobe.
- regfile_wr_addr  in  5  destination register.
- regfile_wr_data  in  DATA_WIDTH  writeback data.
- thread_index_wb  in  TID_WIDTH  thread of the writeback.
- dmem_write_enable  in  4  byte write strobes.
- dmem_addr  in  ADDR_WIDTH  store address.
- dmem_write_data  in  DATA_WIDTH  store data.
- thread_index_wrmem  in  TID_WIDTH  thread of the store.
- cfg_enable  in  1  capture enable.
- cfg_stop_on_full  in  1  1: freeze when full; 0: drop and count.
- cfg_thread_mask  in  NUM_THREADS  per-thread capture enable.
- o_trace_valid  out  1  head entry valid.
- i_trace_ready  in  1  consumer accepts the head entry.
- o_trace_kind  out  1  0 = register write, 1 = memory write.
- o_trace_tid  out  TID_WIDTH  thread.
- o_trace_addr  out  ADDR_WIDTH  address.
- o_trace_data  out  DATA_WIDTH  data.
- o_trace_be  out  4  byte enables (4'hF for register events).
- o_trace_seq  out  SEQ_WIDTH  sequence stamp.
- o_level  out  $clog2(DEPTH)+1  occupancy.
- o_overflow_count  out  16  dropped events, saturating.
- o_frozen  out  1  state is FROZEN.

Behaviour:
- Reset (reset low, async): all outputs 0, FIFO empty, seq = 0, overflow = 0, state IDLE.
- State machine:
  - IDLE -> CAPTURE when cfg_enable = 1.
  - CAPTURE -> IDLE when cfg_enable = 0.
  - CAPTURE -> FROZEN when cfg_stop_on_full = 1 and an event finds insufficient space.
  - FROZEN -> IDLE only when cfg_enable = 0.
  - Draining continues in every state.
- Register event: regfile_wr_en, mask[thread_index_wb] = 1, and not (FILTER_X0 and addr = 0).
- Memory event: dmem_write_enable != 0 and mask[thread_index_wrmem] = 1.
- Events are sampled only in CAPTURE, on the clock edge.
- Sequence stamping:
  - Each event observed in CAPTURE consumes one seq value, whether accepted or dropped; gaps reveal drops.
  - On a simultaneous pair, the register event takes seq and the memory event takes seq+1.
  - seq wraps modulo 2^SEQ_WIDTH.
- Space check uses the registered level, free = DEPTH - o_level. A pop in the same cycle does not create space.
- Simultaneous pair with free >= 2: both written; register event first, memory event second.
- Simultaneous pair with free = 1: the register event is written and the memory event is dropped.
- Free = 0: all events in that cycle are dropped.
- Drop handling when cfg_stop_on_full = 0: overflow += number dropped (0/1/2), saturating at 16'hFFFF.
- Drop handling when cfg_stop_on_full = 1: dropped events also go to FROZEN the following cycle and are counted; no further capture until re-arm.
- Re-arm via IDLE does not clear the FIFO, seq or overflow. Only reset clears them.
- Write latency: an event at edge N is visible at the head (if the FIFO was empty) with o_trace_valid = 1 after edge N, i.e. cycle N+1. Output is first-word fall-through.
- Handshake: pop on o_trace_valid && i_trace_ready. Outputs hold stable while valid && !ready. No combinational path from i_trace_ready to o_trace_valid.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. o_level = wr_ptr - rd_ptr; full when o_level = DEPTH.
- Same-cycle push and pop: level changes by pushes - pops.

Decomposition:
- Package riscv_pkg gains trace_kind_e (TRACE_REG, TRACE_MEM), trace_entry_t (kind, tid, addr, data, be, seq) and trace_state_e (IDLE, CAPTURE, FROZEN).
- One sub-module: trace_fifo_2w1r, a 2-write/1-read register-array FIFO parametrised on DEPTH and the entry type.
- Capture/qualification logic, the FSM and the counters stay in the top.

Test Plan:
- Mask = 16'hFFFF; reg write x5 = 0x1234 on thread 3 -> entry {kind 0, tid 3, addr 5, data 0x1234, be F, seq 0}, valid on the next cycle.
- Same cycle: reg write x1 on thread 2 and store be = 4'h3 at addr 0x10 on thread 7 -> two entries, reg first, seq 0 then 1.
- Mask = 16'h0001; writes on threads 0 and 1; also x0 on thread 0 -> only the thread-0 non-x0 entry captured; seq advances by 1.
- DEPTH = 4, ready held 0, stop_on_full = 0, six single events -> level 4, overflow 2, head seq 0, captured seqs 0–3.
- Same fill with stop_on_full = 1 -> o_frozen = 1 after the first drop; later events ignored; drain 4 entries; toggle cfg_enable to resume at the next seq.
- Reset asserted mid-drain with level 3 -> o_trace_valid = 0, o_level = 0 and overflow = 0 immediately (async).
